// File: rtl/pciei_slice_pkg.sv
// rtl/pciei_slice_pkg.sv - shared state encodings for the PCIe slice library stages
package pciei_slice_pkg;

  // Buffer fill states; the encoding equals the number of beats held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } slice_state_e;

  // Beats held by a slice in the given state.
  function automatic logic [1:0] occupancy_of(slice_state_e st);
    case (st)
      ST_EMPTY: occupancy_of = 2'd0;
      ST_BUSY:  occupancy_of = 2'd1;
      ST_FULL:  occupancy_of = 2'd2;
      default:  occupancy_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slice_skid.sv
// rtl/pipe_slice_skid.sv - full-throughput two-entry skid register slice
module pipe_slice_skid
  import pciei_slice_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_d,
  input  logic                  rst_d,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occupancy
);

  slice_state_e          state_q;
  slice_state_e          state_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  s_ready_q;
  logic                  m_valid_q;

  logic                  in_hs;
  logic                  out_hs;
  logic                  ld_main_from_s;
  logic                  ld_main_from_skid;
  logic                  ld_skid;

  // Handshakes use only registered ready/valid, so neither crosses the slice combinationally.
  assign in_hs  = s_valid & s_ready_q;
  assign out_hs = m_valid_q & m_ready;

  // Next-state and data-load decode; flush overrides everything and empties the slice.
  always_comb begin
    state_d           = state_q;
    ld_main_from_s    = 1'b0;
    ld_main_from_skid = 1'b0;
    ld_skid           = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_hs) begin
          ld_main_from_s = 1'b1;
          state_d        = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_hs && out_hs) begin
          ld_main_from_s = 1'b1;
        end else if (in_hs) begin
          ld_skid = 1'b1;
          state_d = ST_FULL;
        end else if (out_hs) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // s_ready is low here, so only the drain side can move.
        if (out_hs) begin
          ld_main_from_skid = 1'b1;
          state_d           = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_d           = ST_EMPTY;
      ld_main_from_s    = 1'b0;
      ld_main_from_skid = 1'b0;
      ld_skid           = 1'b0;
    end
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk_d) begin
    if (rst_d) begin
      state_q   <= ST_EMPTY;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d != ST_FULL);
      m_valid_q <= (state_d != ST_EMPTY);
    end
  end

  // Payload registers; the skid beat always refills main before any newer beat.
  always_ff @(posedge clk_d) begin
    if (rst_d) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_from_s) begin
        main_q <= s_data;
      end else if (ld_main_from_skid) begin
        main_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= s_data;
      end
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = main_q;
  assign occupancy = occupancy_of(state_q);

endmodule

// File: tb/tb_pipe_slice_skid.sv
// tb/tb_pipe_slice_skid.sv - directed self-checking bench for pipe_slice_skid
module tb_pipe_slice_skid;

  localparam int DW = 64;

  logic          clk_d = 1'b0;
  logic          rst_d;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    occupancy;

  int checks = 0;
  int errors = 0;

  pipe_slice_skid #(.DATA_WIDTH(DW)) dut (
    .clk_d     (clk_d),
    .rst_d     (rst_d),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
  );

  always #5 clk_d = ~clk_d;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_d);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] q[$];
    logic [DW-1:0] next_beat;
    logic [DW-1:0] held_data;
    logic          hold;
    logic          sv;
    logic          mr;
    int            sent;
    int            cyc;

    rst_d = 1'b1; flush = 1'b0; s_valid = 1'b1; s_data = 64'hDEAD; m_ready = 1'b0;

    // 1. reset held three cycles with s_valid high
    tick(); tick(); tick();
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_occ", {62'd0, occupancy}, 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    rst_d = 1'b0;
    tick();
    chk("rel_s_ready", {63'd0, s_ready}, 64'd1);
    chk("rel_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rel_occ", {62'd0, occupancy}, 64'd0);
    s_valid = 1'b0;

    // 2. back-to-back streaming
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1; s_data = 64'(i);
      tick();
      chk("str_m_valid", {63'd0, m_valid}, 64'd1);
      chk("str_m_data", m_data, 64'(i));
      chk("str_s_ready", {63'd0, s_ready}, 64'd1);
      chk("str_occ", {62'd0, occupancy}, 64'd1);
    end
    s_valid = 1'b0;
    tick();
    chk("str_drain", {63'd0, m_valid}, 64'd0);

    // 3. skid fill and drain
    s_valid = 1'b1; s_data = 64'hA0;
    tick();
    chk("skid_a0", m_data, 64'hA0);
    m_ready = 1'b0; s_data = 64'hA1;
    tick();
    chk("skid_occ2", {62'd0, occupancy}, 64'd2);
    chk("skid_s_ready0", {63'd0, s_ready}, 64'd0);
    chk("skid_hold_a0", m_data, 64'hA0);
    s_data = 64'hA2;
    tick();
    chk("skid_still_a0", m_data, 64'hA0);
    chk("skid_still_occ2", {62'd0, occupancy}, 64'd2);
    m_ready = 1'b1;
    tick();
    chk("skid_a1", m_data, 64'hA1);
    chk("skid_a1_valid", {63'd0, m_valid}, 64'd1);
    chk("skid_ready_back", {63'd0, s_ready}, 64'd1);
    tick();
    chk("skid_a2", m_data, 64'hA2);
    chk("skid_a2_occ", {62'd0, occupancy}, 64'd1);
    s_valid = 1'b0;
    tick();
    chk("skid_empty", {63'd0, m_valid}, 64'd0);

    // 4. random backpressure with scoreboard
    next_beat = 64'h1000;
    sent = 0;
    cyc = 0;
    while ((sent < 10000 || q.size() != 0) && cyc < 80000) begin
      sv = (sent < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      mr = 1'($urandom_range(0, 1));
      s_valid = sv; s_data = next_beat; m_ready = mr;
      if (m_valid && mr) begin
        if (q.size() == 0) chk("rnd_unexpected", m_data, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("rnd_order", m_data, q.pop_front());
      end
      if (sv && s_ready) begin
        q.push_back(next_beat);
        next_beat = next_beat + 64'd1;
        sent++;
      end
      hold = m_valid && !mr;
      held_data = m_data;
      tick();
      cyc++;
      if (hold) begin
        chk("rnd_stable_valid", {63'd0, m_valid}, 64'd1);
        chk("rnd_stable_data", m_data, held_data);
      end
      chk("rnd_occ", {62'd0, occupancy}, 64'(q.size()));
    end
    chk("rnd_all_sent", 64'(sent), 64'd10000);
    chk("rnd_all_drained", 64'(q.size()), 64'd0);
    s_valid = 1'b0; m_ready = 1'b1;
    tick();

    // 5. flush while full with s_valid high
    m_ready = 1'b0; s_valid = 1'b1; s_data = 64'h11;
    tick();
    s_data = 64'h12;
    tick();
    chk("fl_occ2", {62'd0, occupancy}, 64'd2);
    flush = 1'b1; s_data = 64'h13;
    tick();
    chk("fl_m_valid", {63'd0, m_valid}, 64'd0);
    chk("fl_occ", {62'd0, occupancy}, 64'd0);
    chk("fl_s_ready", {63'd0, s_ready}, 64'd1);
    flush = 1'b0; s_data = 64'h55; m_ready = 1'b1;
    tick();
    chk("fl_55_valid", {63'd0, m_valid}, 64'd1);
    chk("fl_55_data", m_data, 64'h55);
    s_valid = 1'b0;
    tick();
    chk("fl_after_55", {63'd0, m_valid}, 64'd0);

    // 6. reset while full
    m_ready = 1'b0; s_valid = 1'b1; s_data = 64'h21;
    tick();
    s_data = 64'h22;
    tick();
    chk("mr_occ2", {62'd0, occupancy}, 64'd2);
    rst_d = 1'b1;
    tick();
    chk("mr_m_valid", {63'd0, m_valid}, 64'd0);
    chk("mr_occ", {62'd0, occupancy}, 64'd0);
    chk("mr_s_ready", {63'd0, s_ready}, 64'd0);
    chk("mr_m_data", m_data, 64'd0);
    rst_d = 1'b0; s_valid = 1'b0;
    tick();
    chk("mr_rel_ready", {63'd0, s_ready}, 64'd1);
    s_valid = 1'b1; s_data = 64'h77; m_ready = 1'b1;
    tick();
    chk("mr_77_valid", {63'd0, m_valid}, 64'd1);
    chk("mr_77_data", m_data, 64'h77);
    s_valid = 1'b0;
    tick();
    chk("mr_done", {63'd0, m_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
